alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Shares one combinational ALU (4-bit func code, 32-bit operands) between two requesters, e.g. the integer pipeline and the address-generation/branch unit.
- Per-requester valid/ready request channel and valid/ready response channel.
- Round-robin arbitration.
- Operands are registered before the ALU and the result is registered after it, so the shared ALU is never driven from a requester's combinational path.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- FUNC_WIDTH, 4, ALU function-code width (codes: ZERO=0, ADD=1, SUB=2, SLL=3, SLT=4, XOR=5, OR=6, AND=7, SRL=8, SRA=9, SLTU=10).

Ports:
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-high
- req0_valid  input  1  requester 0 has an operation
- req0_ready  output  1  requester 0 operation accepted this cycle
- req0_func  input  FUNC_WIDTH  requester 0 ALU function
- req0_op1  input  DATA_WIDTH  requester 0 operand 1
- req0_op2  input  DATA_WIDTH  requester 0 operand 2
- rsp0_valid  output  1  requester 0 result available
- rsp0_ready  input  1  requester 0 consumes result
- rsp0_data  output  DATA_WIDTH  requester 0 result
- req1_valid, req1_ready, req1_func, req1_op1, req1_op2, rsp1_valid, rsp1_ready, rsp1_data: same as requester 0, for requester 1
- alu_func  output  FUNC_WIDTH  to shared ALU
- alu_op1  output  DATA_WIDTH  to shared ALU
- alu_op2  output  DATA_WIDTH  to shared ALU
- alu_result  input  DATA_WIDTH  from shared ALU (combinational)

Behaviour:
- FSM states: IDLE, EXEC, RESP. Registers: state, owner (1 bit), last_grant (1 bit), func_q, op1_q, op2_q, rsp_data_q.
- Reset values:
  - state=IDLE, last_grant=1 (requester 0 wins first tie), owner=0.
  - func_q=0 (ZERO), op1_q=op2_q=rsp_data_q=0.
  - req*_ready=0, rsp*_valid=0, rsp*_data=0.
  - alu_func=0, alu_op1=alu_op2=0.
- IDLE:
  - Grant rule:
    - Only one requester valid: it is granted.
    - Both valid: the requester != last_grant is granted.
    - None valid: stay in IDLE.
  - reqN_ready = (state==IDLE) && granted==N. This is combinational from valids and registers; at most one ready is high per cycle.
  - On handshake: latch func/op1/op2 into *_q, owner=N, last_grant=N, go to EXEC.
- EXEC:
  - alu_func/op1/op2 driven from *_q.
  - rsp_data_q <= alu_result; go to RESP.
  - Outside EXEC, alu_func=0 and alu_op1=alu_op2=0.
- RESP:
  - rsp{owner}_valid=1; rsp{owner}_data=rsp_data_q. The other rsp_valid is 0.
  - Hold data stable until rsp{owner}_ready=1, then go to IDLE.
  - Ready high on the first RESP cycle leaves after 1 cycle.
- Latency:
  - Request handshake at cycle N: rsp_valid is high at N+2.
  - Minimum 3 cycles per operation; no new request is accepted in EXEC/RESP.
- Requester rule: op fields must be held stable while valid && !ready. The block does not check this.
- Non-owner rsp*_data reads 0.
- Reset mid-operation: immediate return to reset values; the in-flight result is discarded and no response is produced.
- Result width: alu_result is passed through unmodified. The block performs no arithmetic.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1, each 16 bits.
  - Each counter increments on its requester's request handshake.
  - Counters saturate at 16'hFFFF and clear on rst.
- When undefined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. Single op: req0 ADD op1=5, op2=7 accepted at cycle N (bench ALU model) -> alu_func=1 at N+1; rsp0_valid=1, rsp0_data=12 at N+2; rsp1_valid stays 0.
2. Contention: both valid every cycle from reset, req0 SUB 10-3, req1 SLT op1=32'hFFFFFFFF, op2=1, both rsp_ready=1 -> grant order 0,1,0,1; rsp0_data=7; rsp1_data=1; accepts spaced 3 cycles apart.
3. Backpressure: req1 XOR 32'hF0F0 ^ 32'h0FF0, rsp1_ready low 4 cycles -> rsp1_valid and rsp1_data=32'hFF00 held stable; req0_ready stays 0 until cycle after rsp1_ready=1.
4. Reset mid-op: assert rst during EXEC of req0 AND -> rsp0_valid never rises; all outputs 0 while rst high; first post-reset tie grants requester 0.
5. Idle quiet: no valids for 10 cycles -> alu_func=0, alu_op1=alu_op2=0, both ready/valid 0.
6. With ALU_ARB_STATS_EN: 3 grants to req0, 2 to req1 -> grant_cnt0=3, grant_cnt1=2; preload via 65536 grants -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// ---------------------------------------------------------------------------
// alu_share_arbiter
//
// Shares a single combinational ALU between two requesters. Each requester
// has a valid/ready request channel (function code + two operands) and a
// valid/ready response channel (result). Only one operation is in flight at
// a time, and it moves through three phases:
//
//   IDLE : pick a requester (round robin on ties) and capture its operands
//   EXEC : drive the captured operands to the ALU, register its result
//   RESP : present the registered result to the owner until it is consumed
//
// The operand registers sit in front of the ALU and the result register
// sits behind it. As a result, no requester combinational path ever reaches
// the shared ALU. An operation accepted in cycle N shows its result in
// cycle N+2. The next accept can happen no earlier than cycle N+3.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid && ready are both high. A request source holds func/op1/op2
// stable while valid && !ready. reqN_ready is a combinational function of the
// request valids and internal registers and does not depend on reqN_func/op.
// While a response is offered, rspN_valid and rspN_data are held stable until
// rspN_ready is sampled high.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req{0,1}_valid/ready          request handshake
//   req{0,1}_func/op1/op2         request payload
//   rsp{0,1}_valid/ready          response handshake
//   rsp{0,1}_data                 response payload (0 when not offered)
//   alu_func/op1/op2              to shared ALU (0 outside EXEC)
//   alu_result                    from shared ALU (combinational)
//   grant_cnt0/1                  saturating 16-bit grant counters
//                                 (only with ALU_ARB_STATS_EN defined)
//   dbg_state_o                   current FSM state (IDLE=0, EXEC=1, RESP=2)
//
// Build option: define ALU_ARB_STATS_EN to add the per-requester grant
// counters. Without it the block has no counters and no counter ports.
// ---------------------------------------------------------------------------
module alu_share_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int FUNC_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [FUNC_WIDTH-1:0] req0_func,
    input  logic [DATA_WIDTH-1:0] req0_op1,
    input  logic [DATA_WIDTH-1:0] req0_op2,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_data,

    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [FUNC_WIDTH-1:0] req1_func,
    input  logic [DATA_WIDTH-1:0] req1_op1,
    input  logic [DATA_WIDTH-1:0] req1_op2,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_data,

    output logic [FUNC_WIDTH-1:0] alu_func,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_result,

`ifdef ALU_ARB_STATS_EN
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1,
`endif

    output logic [1:0]            dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_grant_q, last_grant_d;
    logic [FUNC_WIDTH-1:0]   func_q, func_d;
    logic [DATA_WIDTH-1:0]   op1_q, op1_d;
    logic [DATA_WIDTH-1:0]   op2_q, op2_d;
    logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;

    // Arbitration: a single valid requester wins outright. On a tie, the
    // requester that did not win last time wins. last_grant resets to 1, so
    // requester 0 wins the first tie after reset.
    logic any_valid;
    logic grant_sel;

    assign any_valid = req0_valid | req1_valid;
    assign grant_sel = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            func_q       <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            rsp_data_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            func_q       <= func_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            rsp_data_q   <= rsp_data_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        func_d       = func_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        rsp_data_d   = rsp_data_q;

        req0_ready   = 1'b0;
        req1_ready   = 1'b0;
        rsp0_valid   = 1'b0;
        rsp1_valid   = 1'b0;
        rsp0_data    = '0;
        rsp1_data    = '0;
        alu_func     = '0;
        alu_op1      = '0;
        alu_op2      = '0;

        unique case (state_q)
            IDLE: begin
                // The ready signals are gated by rst. As a result, every
                // output reads 0 while reset is held, even if a requester
                // keeps valid high.
                if (any_valid && !rst) begin
                    req0_ready   = ~grant_sel;
                    req1_ready   = grant_sel;
                    owner_d      = grant_sel;
                    last_grant_d = grant_sel;
                    func_d       = grant_sel ? req1_func : req0_func;
                    op1_d        = grant_sel ? req1_op1  : req0_op1;
                    op2_d        = grant_sel ? req1_op2  : req0_op2;
                    state_d      = EXEC;
                end
            end

            EXEC: begin
                alu_func   = func_q;
                alu_op1    = op1_q;
                alu_op2    = op2_q;
                rsp_data_d = alu_result;
                state_d    = RESP;
            end

            RESP: begin
                if (owner_q == 1'b0) begin
                    rsp0_valid = 1'b1;
                    rsp0_data  = rsp_data_q;
                    if (rsp0_ready) begin
                        state_d = IDLE;
                    end
                end else begin
                    rsp1_valid = 1'b1;
                    rsp1_data  = rsp_data_q;
                    if (rsp1_ready) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dbg_state_o = state_q;

`ifdef ALU_ARB_STATS_EN
    // ------------------------------------------------------------------
    // Grant statistics: each counter counts its requester's accepted
    // requests and holds at all-ones instead of wrapping.
    // ------------------------------------------------------------------
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (req0_ready && cnt0_q != 16'hFFFF) begin
            cnt0_d = cnt0_q + 16'd1;
        end
        if (req1_ready && cnt1_q != 16'hFFFF) begin
            cnt1_d = cnt1_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule
